// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO (data + TLAST), first-word-fall-through, optional store-and-forward with oversize-packet drop.
// Latency: a beat is visible on m_axis the cycle after its write (cut-through) or after its packet's TLAST write (packet mode).
// Backpressure: s_axis_tready = !full while accepting; forced high while discarding an oversize packet.
module axis_pkt_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 0,
    parameter int AF_THRESH   = DEPTH - 2,
    parameter int AE_THRESH   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tlast,
    output logic                       s_axis_tready,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       pkt_dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] AF_P    = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_P    = PW'(AE_THRESH);

    typedef enum logic {ACCEPT, DROP} state_t;

    // Storage: TLAST kept in the top bit alongside the data.
    logic [DATA_WIDTH:0] r_mem [DEPTH];

    state_t        r_state;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_commit_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_pkt_dropped;

    state_t        w_state_nxt;
    logic [PW-1:0] w_wr_ptr_nxt;
    logic [PW-1:0] w_commit_ptr_nxt;
    logic          w_drop_pulse;
    logic          w_mem_we;

    logic [PW-1:0] w_level;
    logic [PW-1:0] w_uncommitted;
    logic          w_full;
    logic          w_empty_vis;
    logic          w_wr;
    logic          w_rd;

    assign w_level       = r_wr_ptr - r_rd_ptr;
    assign w_uncommitted = r_wr_ptr - r_commit_ptr;
    assign w_full        = (w_level == DEPTH_P);
    assign w_empty_vis   = (r_commit_ptr == r_rd_ptr);

    assign s_axis_tready = (r_state == DROP) ? 1'b1 : !w_full;
    assign m_axis_tvalid = !w_empty_vis;
    assign w_wr          = s_axis_tvalid && s_axis_tready;
    assign w_rd          = m_axis_tvalid && m_axis_tready;

    // Head entry is read combinationally; it only moves when rd_ptr advances, so it holds under stall.
    assign {m_axis_tlast, m_axis_tdata} = r_mem[r_rd_ptr[AW-1:0]];

    assign level        = w_level;
    assign almost_full  = (w_level >= AF_P);
    assign almost_empty = (w_level <= AE_P);
    assign pkt_dropped  = r_pkt_dropped;

    // Write-side FSM: next state, write/commit pointer updates and drop pulse.
    always_comb begin
        w_state_nxt      = r_state;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_commit_ptr_nxt = r_commit_ptr;
        w_drop_pulse     = 1'b0;
        w_mem_we         = 1'b0;
        case (r_state)
            ACCEPT: begin
                if (w_wr) begin
                    w_mem_we     = 1'b1;
                    w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
                    // Cut-through exposes every beat; packet mode only on TLAST.
                    if (PACKET_MODE == 0 || s_axis_tlast) begin
                        w_commit_ptr_nxt = r_wr_ptr + PTR_ONE;
                    end
                end else if (PACKET_MODE != 0 && w_full && (w_uncommitted == DEPTH_P)) begin
                    // The partial packet owns the whole buffer and can never complete: discard it.
                    w_state_nxt  = DROP;
                    w_wr_ptr_nxt = r_commit_ptr;
                end
            end
            DROP: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    w_state_nxt  = ACCEPT;
                    w_drop_pulse = 1'b1;
                end
            end
            default: w_state_nxt = ACCEPT;
        endcase
    end

    // State and pointer registers; reset discards any partial or dropping packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ACCEPT;
            r_wr_ptr      <= '0;
            r_commit_ptr  <= '0;
            r_rd_ptr      <= '0;
            r_pkt_dropped <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_commit_ptr  <= w_commit_ptr_nxt;
            r_rd_ptr      <= w_rd ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
            r_pkt_dropped <= w_drop_pulse;
        end
    end

    // Memory write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
        end
    end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: one cut-through and one packet-mode instance, DEPTH=16.
// Directed stimulus pushes expected {tlast,data} into per-instance queues; monitors pop on each output handshake.
// Inputs change #1 after the rising edge; everything is sampled on the falling edge.
module tb_axis_pkt_fifo;

    logic       clk;
    logic       rst;

    logic [7:0] ct_s_tdata, pm_s_tdata;
    logic       ct_s_tvalid, pm_s_tvalid;
    logic       ct_s_tlast, pm_s_tlast;
    logic       ct_s_tready, pm_s_tready;
    logic [7:0] ct_m_tdata, pm_m_tdata;
    logic       ct_m_tvalid, pm_m_tvalid;
    logic       ct_m_tlast, pm_m_tlast;
    logic       ct_m_tready, pm_m_tready;
    logic [4:0] ct_level, pm_level;
    logic       ct_af, pm_af, ct_ae, pm_ae;
    logic       ct_drop, pm_drop;

    logic [8:0] q_ct[$];
    logic [8:0] q_pm[$];
    int         n_vec;
    int         n_err;
    int         drop_cnt;

    axis_pkt_fifo #(.DATA_WIDTH(8), .DEPTH(16), .PACKET_MODE(0)) u_ct (
        .clk(clk), .rst(rst),
        .s_axis_tdata(ct_s_tdata), .s_axis_tvalid(ct_s_tvalid), .s_axis_tlast(ct_s_tlast),
        .s_axis_tready(ct_s_tready),
        .m_axis_tdata(ct_m_tdata), .m_axis_tvalid(ct_m_tvalid), .m_axis_tlast(ct_m_tlast),
        .m_axis_tready(ct_m_tready),
        .level(ct_level), .almost_full(ct_af), .almost_empty(ct_ae), .pkt_dropped(ct_drop)
    );

    axis_pkt_fifo #(.DATA_WIDTH(8), .DEPTH(16), .PACKET_MODE(1)) u_pm (
        .clk(clk), .rst(rst),
        .s_axis_tdata(pm_s_tdata), .s_axis_tvalid(pm_s_tvalid), .s_axis_tlast(pm_s_tlast),
        .s_axis_tready(pm_s_tready),
        .m_axis_tdata(pm_m_tdata), .m_axis_tvalid(pm_m_tvalid), .m_axis_tlast(pm_m_tlast),
        .m_axis_tready(pm_m_tready),
        .level(pm_level), .almost_full(pm_af), .almost_empty(pm_ae), .pkt_dropped(pm_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cut-through monitor: every output handshake must match the next expected beat.
    always @(negedge clk) begin
        if (!rst && ct_m_tvalid && ct_m_tready) begin
            if (q_ct.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL ct_unexpected: got beat 0x%0h, expected none", {ct_m_tlast, ct_m_tdata});
            end else begin
                check("ct_out", {23'd0, ct_m_tlast, ct_m_tdata}, {23'd0, q_ct.pop_front()});
            end
        end
    end

    // Packet-mode monitor.
    always @(negedge clk) begin
        if (!rst && pm_m_tvalid && pm_m_tready) begin
            if (q_pm.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pm_unexpected: got beat 0x%0h, expected none", {pm_m_tlast, pm_m_tdata});
            end else begin
                check("pm_out", {23'd0, pm_m_tlast, pm_m_tdata}, {23'd0, q_pm.pop_front()});
            end
        end
    end

    // Counts cycles with pkt_dropped high on the packet-mode instance.
    always @(negedge clk) begin
        if (!rst && pm_drop) drop_cnt++;
    end

    // Issue one beat (called #1 after a rising edge); returns #1 after the accepting edge.
    task automatic send(input bit pm, input logic [7:0] d, input logic last, input bit expect_out);
        bit ok;
        ok = 1'b0;
        if (pm) begin
            pm_s_tdata = d; pm_s_tlast = last; pm_s_tvalid = 1'b1;
            if (expect_out) q_pm.push_back({last, d});
        end else begin
            ct_s_tdata = d; ct_s_tlast = last; ct_s_tvalid = 1'b1;
            if (expect_out) q_ct.push_back({last, d});
        end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (pm ? pm_s_tready : ct_s_tready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: beat 0x%0h never accepted, expected acceptance", d);
        end
        @(posedge clk);
        #1;
        ct_s_tvalid = 1'b0;
        pm_s_tvalid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 300; k++) begin
            if (q_ct.size() == 0 && q_pm.size() == 0 && !ct_m_tvalid && !pm_m_tvalid) break;
            @(posedge clk);
            #1;
        end
        check("ct_drain_left", q_ct.size(), 0);
        check("pm_drain_left", q_pm.size(), 0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0; n_err = 0; drop_cnt = 0;
        rst = 1'b1;
        ct_s_tdata = '0; ct_s_tvalid = 1'b0; ct_s_tlast = 1'b0; ct_m_tready = 1'b0;
        pm_s_tdata = '0; pm_s_tvalid = 1'b0; pm_s_tlast = 1'b0; pm_m_tready = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ct_tready", ct_s_tready, 1);
        check("rst_ct_tvalid", ct_m_tvalid, 0);
        check("rst_ct_level", ct_level, 0);
        check("rst_ct_ae", ct_ae, 1);
        check("rst_ct_af", ct_af, 0);
        check("rst_pm_tready", pm_s_tready, 1);
        check("rst_pm_tvalid", pm_m_tvalid, 0);
        check("rst_pm_drop", pm_drop, 0);
        rst = 1'b0;
        next_cycle();

        // Cut-through: fill all 16 entries with the consumer stalled
        for (int i = 0; i < 16; i++) send(1'b0, 8'(i), (i == 7 || i == 15), 1'b1);
        @(negedge clk);
        check("ct_full_tready", ct_s_tready, 0);
        check("ct_full_level", ct_level, 16);
        check("ct_full_af", ct_af, 1);
        check("ct_full_ae", ct_ae, 0);
        for (int i = 0; i < 3; i++) begin
            check("ct_stall_tvalid", ct_m_tvalid, 1);
            check("ct_stall_head", ct_m_tdata, 8'h00);
            @(negedge clk);
        end
        next_cycle();
        ct_m_tready = 1'b1;
        drain();
        @(negedge clk);
        check("ct_empty_ae", ct_ae, 1);
        check("ct_empty_level", ct_level, 0);
        next_cycle();

        // Cut-through: simultaneous read/write at level 8
        ct_m_tready = 1'b0;
        for (int i = 0; i < 8; i++) send(1'b0, 8'h10 + 8'(i), 1'b0, 1'b1);
        @(negedge clk);
        check("ct_lvl8", ct_level, 8);
        next_cycle();
        ct_m_tready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ct_s_tdata  = 8'h18 + 8'(i);
            ct_s_tlast  = (i == 19);
            ct_s_tvalid = 1'b1;
            q_ct.push_back({ct_s_tlast, ct_s_tdata});
            @(negedge clk);
            check("ct_sim_level", ct_level, 8);
            check("ct_sim_tready", ct_s_tready, 1);
            next_cycle();
        end
        ct_s_tvalid = 1'b0;
        drain();

        // Packet mode: 5-beat packet only visible after its TLAST write
        pm_m_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 8'hA0 + 8'(i), (i == 4), 1'b1);
            @(negedge clk);
            check("pm_vis", pm_m_tvalid, (i == 4) ? 1 : 0);
            next_cycle();
        end
        drain();

        // Packet mode: 20-beat oversize packet dropped, then a 3-beat packet passes
        drop_cnt = 0;
        for (int i = 0; i < 20; i++) send(1'b1, 8'h40 + 8'(i), (i == 19), 1'b0);
        @(negedge clk);
        check("pm_drop_pulse", pm_drop, 1);
        check("pm_drop_level", pm_level, 0);
        check("pm_drop_tvalid", pm_m_tvalid, 0);
        next_cycle();
        @(negedge clk);
        check("pm_drop_pulse_end", pm_drop, 0);
        next_cycle();
        for (int i = 0; i < 3; i++) send(1'b1, 8'h50 + 8'(i), (i == 2), 1'b1);
        drain();
        check("pm_drop_count", drop_cnt, 1);

        // Packet mode: exactly 16 beats is committed, not dropped
        pm_m_tready = 1'b0;
        for (int i = 0; i < 16; i++) send(1'b1, 8'h60 + 8'(i), (i == 15), 1'b1);
        @(negedge clk);
        check("pm16_drop", pm_drop, 0);
        check("pm16_level", pm_level, 16);
        check("pm16_tvalid", pm_m_tvalid, 1);
        check("pm16_tready", pm_s_tready, 0);
        next_cycle();
        pm_m_tready = 1'b1;
        drain();
        check("pm16_drop_count", drop_cnt, 1);

        // Reset while a partial packet is pending and the consumer is stalled
        pm_m_tready = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
        @(negedge clk);
        check("pm_partial_level", pm_level, 3);
        check("pm_partial_tvalid", pm_m_tvalid, 0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_level", pm_level, 0);
        check("rst_mid_tvalid", pm_m_tvalid, 0);
        check("rst_mid_tready", pm_s_tready, 1);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_drop", pm_drop, 0);
        next_cycle();
        pm_m_tready = 1'b1;
        send(1'b1, 8'h80, 1'b0, 1'b1);
        send(1'b1, 8'h81, 1'b1, 1'b1);
        drain();
        check("rst_drop_count", drop_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
